// File: rtl/sb_bridge_arbiter.sv
// Two-master arbiter for the system-bridge device window.
// Optional ISSUE timeout: define SB_ARB_TIMEOUT_EN.
module sb_bridge_arbiter #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_7F00,
  parameter int          WINDOW_BYTES = 32,
  parameter int          TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  output logic        m0_exc,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        m1_exc,

  output logic        s_valid,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  input  logic        s_exc
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [31:0] WIN = 32'(WINDOW_BYTES);

  logic [1:0]  state;
  logic        owner;
  logic        prio;

  logic        grant_any;
  logic        grant_sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [31:0] offset;
  logic        legal;

  logic        fire;
  logic        tmo;

  logic        done_set;
  logic        done_who;
  logic [31:0] done_rdata;
  logic        done_exc;

  // Pick a winner: single requester wins, ties go to prio.
  always_comb begin
    grant_any = m0_req | m1_req;
    grant_sel = 1'b0;
    unique case (1'b1)
      (m0_req && m1_req): grant_sel = prio;
      (m1_req && !m0_req): grant_sel = 1'b1;
      default: grant_sel = 1'b0;
    endcase
  end

  // Route the winner's request fields.
  always_comb begin
    sel_we    = grant_sel ? m1_we    : m0_we;
    sel_addr  = grant_sel ? m1_addr  : m0_addr;
    sel_wdata = grant_sel ? m1_wdata : m0_wdata;
  end

  // Window and alignment check; wrap-around rejects low addresses.
  always_comb begin
    offset = sel_addr - BASE_ADDR;
    legal  = (offset < WIN) && (sel_addr[1:0] == 2'b00);
  end

  assign fire = (state == ISSUE) && s_valid && s_ready;

`ifdef SB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Count ISSUE cycles; any other state clears it for the next issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state != ISSUE) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tmo = (state == ISSUE) && !s_ready && (cnt == LAST);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo = 1'b0;
`endif

  // Decide whether a response is produced this cycle and its contents.
  always_comb begin
    done_set   = 1'b0;
    done_who   = owner;
    done_rdata = '0;
    done_exc   = 1'b0;
    unique case (1'b1)
      ((state == IDLE) && grant_any && !legal): begin
        done_set = 1'b1;
        done_who = grant_sel;
        done_exc = 1'b1;
      end
      fire: begin
        done_set   = 1'b1;
        done_rdata = s_we ? 32'h0 : s_rdata;
        done_exc   = s_exc;
      end
      tmo: begin
        done_set = 1'b1;
        done_exc = 1'b1;
      end
      default: done_set = 1'b0;
    endcase
  end

  // Main FSM plus owner and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= 1'b0;
      prio  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            owner <= grant_sel;
            state <= legal ? ISSUE : RESP;
          end
        end
        ISSUE: begin
          if (fire || tmo) begin
            state <= RESP;
          end
        end
        RESP: begin
          prio  <= ~owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slave request registers, held stable for the whole ISSUE phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_valid <= 1'b0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
    end else if ((state == IDLE) && grant_any && legal) begin
      s_valid <= 1'b1;
      s_we    <= sel_we;
      s_addr  <= {sel_addr[31:2], 2'b00};
      s_wdata <= sel_wdata;
    end else if (fire || tmo) begin
      s_valid <= 1'b0;
    end
  end

  // m0 response: pulse done, hold rdata/exc until its next done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_done  <= 1'b0;
      m0_rdata <= '0;
      m0_exc   <= 1'b0;
    end else begin
      m0_done <= done_set && !done_who;
      if (done_set && !done_who) begin
        m0_rdata <= done_rdata;
        m0_exc   <= done_exc;
      end
    end
  end

  // m1 response: pulse done, hold rdata/exc until its next done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m1_done  <= 1'b0;
      m1_rdata <= '0;
      m1_exc   <= 1'b0;
    end else begin
      m1_done <= done_set && done_who;
      if (done_set && done_who) begin
        m1_rdata <= done_rdata;
        m1_exc   <= done_exc;
      end
    end
  end

endmodule

// File: tb/tb_sb_bridge_arbiter.sv
// Directed bench for sb_bridge_arbiter.
// Inputs change #1 after posedge; outputs are checked there too.
module tb_sb_bridge_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we;
  logic [31:0] m0_addr, m0_wdata;
  logic        m0_done, m0_exc;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_we;
  logic [31:0] m1_addr, m1_wdata;
  logic        m1_done, m1_exc;
  logic [31:0] m1_rdata;
  logic        s_valid, s_we;
  logic [31:0] s_addr, s_wdata;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        s_exc;

  int checks = 0;
  int errors = 0;
  int n;
  int nv;

  logic [31:0] bad_addr [3];

  sb_bridge_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_done  (m0_done),
    .m0_rdata (m0_rdata),
    .m0_exc   (m0_exc),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_done  (m1_done),
    .m1_rdata (m1_rdata),
    .m1_exc   (m1_exc),
    .s_valid  (s_valid),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .s_exc    (s_exc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    s_ready = 0; s_rdata = 0; s_exc = 0;
    bad_addr[0] = 32'h0000_7F02;
    bad_addr[1] = 32'h0000_7F20;
    bad_addr[2] = 32'h0000_2FFC;

    // 1: reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_s_we", 32'(s_we), 32'd0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_s_wdata", s_wdata, 32'h0);
    chk("rst_m0", {m0_done, m0_exc, 30'd0}, 32'h0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1", {m1_done, m1_exc, 30'd0}, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    reset = 1'b1;
    tick();

    // 1: async reset aborts a stalled issue
    m0_req = 1; m0_we = 0; m0_addr = 32'h7F10;
    tick();
    chk("abort_valid_up", 32'(s_valid), 32'd1);
    m0_req = 0;
    tick();
    chk("abort_valid_hold", 32'(s_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_valid_async", 32'(s_valid), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("abort_no_done0", {m0_done, m1_done, m0_exc, m1_exc}, 32'h0);
    tick();
    chk("abort_no_done1", {m0_done, m1_done, m0_exc, m1_exc}, 32'h0);

    // 3: ties alternate m0,m1,m0,m1 starting with m0
    s_ready = 1; s_rdata = 32'h5A5A_0001;
    m0_addr = 32'h7F00; m1_addr = 32'h7F04;
    for (int i = 0; i < 4; i++) begin
      m0_req = 1; m1_req = 1;
      n = 0;
      while (!(m0_done || m1_done) && n < 20) begin
        tick();
        n++;
      end
      chk($sformatf("rr_bound%0d", i), 32'(n < 20), 32'd1);
      chk($sformatf("rr_m0_%0d", i), 32'(m0_done), 32'(i % 2 == 0));
      chk($sformatf("rr_m1_%0d", i), 32'(m1_done), 32'(i % 2 == 1));
      if (m0_done) m0_req = 0;
      else m1_req = 0;
      tick();
    end
    m0_req = 0; m1_req = 0; s_ready = 0;
    tick();
    tick();

    // 2: minimum latency read
    m0_req = 1; m0_we = 0; m0_addr = 32'h7F04;
    s_rdata = 32'hDEAD_BEEF;
    tick();
    chk("rd_valid", 32'(s_valid), 32'd1);
    chk("rd_addr", s_addr, 32'h7F04);
    chk("rd_we", 32'(s_we), 32'd0);
    chk("rd_early_done", 32'(m0_done), 32'd0);
    s_ready = 1;
    tick();
    chk("rd_done", 32'(m0_done), 32'd1);
    chk("rd_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("rd_exc", 32'(m0_exc), 32'd0);
    chk("rd_valid_drop", 32'(s_valid), 32'd0);
    m0_req = 0;
    tick();
    chk("rd_done_once", 32'(m0_done), 32'd0);
    chk("rd_rdata_hold", m0_rdata, 32'hDEAD_BEEF);
    tick();
    chk("stray_ready", {m0_done, m1_done, s_valid}, 32'h0);
    s_ready = 0;

    // 2b: top word of window, slave error
    m0_req = 1; m0_addr = 32'h7F1C;
    s_rdata = 32'h0BAD_F00D; s_exc = 1; s_ready = 1;
    tick();
    chk("top_valid", 32'(s_valid), 32'd1);
    m0_req = 0;
    tick();
    chk("top_done", 32'(m0_done), 32'd1);
    chk("top_exc", 32'(m0_exc), 32'd1);
    chk("top_rdata", m0_rdata, 32'h0BAD_F00D);
    s_ready = 0; s_exc = 0;
    tick();

    // 4: m1 write with 3 stall cycles
    m1_req = 1; m1_we = 1; m1_addr = 32'h7F08;
    m1_wdata = 32'h1234_5678; s_rdata = 32'hAAAA_5555;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("wr_valid%0d", k), 32'(s_valid), 32'd1);
      chk($sformatf("wr_wdata%0d", k), s_wdata, 32'h1234_5678);
      chk($sformatf("wr_addr%0d", k), s_addr, 32'h7F08);
      chk($sformatf("wr_we%0d", k), 32'(s_we), 32'd1);
      chk($sformatf("wr_nodone%0d", k), 32'(m1_done), 32'd0);
      if (k == 1) m1_req = 0;
      if (k == 3) s_ready = 1;
    end
    tick();
    chk("wr_done", 32'(m1_done), 32'd1);
    chk("wr_exc", 32'(m1_exc), 32'd0);
    chk("wr_rdata", m1_rdata, 32'h0);
    chk("wr_loser_done", 32'(m0_done), 32'd0);
    chk("wr_loser_rdata", m0_rdata, 32'h0BAD_F00D);
    s_ready = 0;
    tick();
    chk("wr_done_once", 32'(m1_done), 32'd0);

    // 5: illegal addresses answer at N+1 without the slave
    m0_we = 0;
    for (int j = 0; j < 3; j++) begin
      m0_req = 1; m0_addr = bad_addr[j];
      tick();
      chk($sformatf("ill_done%0d", j), 32'(m0_done), 32'd1);
      chk($sformatf("ill_exc%0d", j), 32'(m0_exc), 32'd1);
      chk($sformatf("ill_rdata%0d", j), m0_rdata, 32'h0);
      chk($sformatf("ill_valid%0d", j), 32'(s_valid), 32'd0);
      m0_req = 0;
      tick();
      chk($sformatf("ill_clr%0d", j), {m0_done, s_valid}, 32'h0);
    end

    // 6: slave never ready
    m0_req = 1; m0_addr = 32'h7F00;
    tick();
    m0_req = 0;
    n = 0; nv = 0;
    while (!m0_done && n < 100) begin
      if (s_valid) nv++;
      tick();
      n++;
    end
`ifdef SB_ARB_TIMEOUT_EN
    chk("tmo_valid_cycles", 32'(nv), 32'd16);
    chk("tmo_done", 32'(m0_done), 32'd1);
    chk("tmo_exc", 32'(m0_exc), 32'd1);
    chk("tmo_rdata", m0_rdata, 32'h0);
    chk("tmo_valid_drop", 32'(s_valid), 32'd0);
`else
    chk("hang_no_done", 32'(m0_done), 32'd0);
    chk("hang_valid", 32'(s_valid), 32'd1);
    chk("hang_cycles", 32'(nv), 32'd100);
    s_ready = 1;
    tick();
    s_ready = 0;
    chk("hang_release", 32'(m0_done), 32'd1);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
